// File: rtl/kmac_sca_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kmac_sca_sequencer
// Description : Single-transaction driver for the reduced KMAC/SHA3 core that
//               is used in side-channel evaluation. It takes one plaintext and
//               one fresh mask, and splits them into two Boolean shares. It
//               then runs the core's start / message / process / done
//               handshake. When the core reports that absorption is finished,
//               it unmasks the low digest bits of the state and returns them.
//               This gives SCA tooling one req/ack transaction per trace.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i / req_ready_o  transaction request; ready only while idle
//   msg_i, mask_i        plaintext and mask, sampled together on req_i
//   digest_o             unmasked digest, held until the next capture
//   digest_valid_o       one-cycle pulse when digest_o is updated
//   error_o / err_clr_i  sticky error flag and its clear
//   kmac_*_o / kmac_*_i  handshake with the masked KMAC core
// ============================================================================
module kmac_sca_sequencer #(
    parameter int unsigned MsgLen        = 128,
    parameter int unsigned DigestW       = 256,
    parameter int unsigned StateW        = 1600,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    output logic                          req_ready_o,
    input  logic [MsgLen-1:0]             msg_i,
    input  logic [MsgLen-1:0]             mask_i,
    output logic [DigestW-1:0]            digest_o,
    output logic                          digest_valid_o,
    output logic                          error_o,
    input  logic                          err_clr_i,
    output logic [1:0][MsgLen-1:0]        kmac_msg_o,
    output logic                          kmac_msg_valid_o,
    input  logic                          kmac_msg_ready_i,
    output logic                          kmac_start_o,
    output logic                          kmac_process_o,
    output logic [3:0]                    kmac_done_o,
    input  logic [3:0]                    kmac_absorbed_i,
    input  logic [1:0][StateW-1:0]        kmac_state_i,
    input  logic                          kmac_state_valid_i,
    input  logic                          kmac_err_i
);

    localparam logic [3:0]  c_mubi4_true  = 4'h6;
    localparam logic [3:0]  c_mubi4_false = 4'h9;
    localparam int unsigned c_cnt_w       = $clog2(TimeoutCycles);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TimeoutCycles - 1);

    // Sparse encoding: one flipped state bit cannot produce another legal
    // state. Any illegal value falls through to ERR.
    typedef enum logic [5:0] {
        ST_IDLE     = 6'b001010,
        ST_START    = 6'b010011,
        ST_MSG      = 6'b100110,
        ST_PROC     = 6'b111100,
        ST_WAIT_ABS = 6'b101001,
        ST_DONE     = 6'b010101,
        ST_ERR      = 6'b110000
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0][MsgLen-1:0] shares_q, shares_d;
    logic [DigestW-1:0]     digest_q, digest_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;

    logic w_timeout;
    logic w_abs_true;
    logic w_abs_false;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign w_timeout   = (cnt_q == c_cnt_max);
    assign w_abs_true  = (kmac_absorbed_i == c_mubi4_true);
    assign w_abs_false = (kmac_absorbed_i == c_mubi4_false);
    // Saturating increment. The counter never wraps back to a value that
    // would hide a timeout.
    assign w_cnt_inc   = w_timeout ? cnt_q : cnt_q + c_cnt_w'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            shares_q <= '0;
            digest_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shares_q <= shares_d;
            digest_q <= digest_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        shares_d         = shares_q;
        digest_d         = digest_q;
        cnt_d            = cnt_q;
        req_ready_o      = 1'b0;
        digest_valid_o   = 1'b0;
        error_o          = 1'b0;
        kmac_msg_valid_o = 1'b0;
        kmac_start_o     = 1'b0;
        kmac_process_o   = 1'b0;
        kmac_done_o      = c_mubi4_false;

        case (state_q)
            ST_IDLE: begin
                // A core error seen while idle is deliberately ignored.
                req_ready_o = 1'b1;
                if (req_i) begin
                    shares_d[0] = msg_i ^ mask_i;
                    shares_d[1] = mask_i;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                kmac_start_o = 1'b1;
                cnt_d        = '0;
                state_d      = kmac_err_i ? ST_ERR : ST_MSG;
            end
            ST_MSG: begin
                kmac_msg_valid_o = 1'b1;
                if (kmac_err_i) begin
                    state_d = ST_ERR;
                end else if (kmac_msg_ready_i) begin
                    // Once the core holds the shares, clear the local copy.
                    shares_d = '0;
                    state_d  = ST_PROC;
                end else if (w_timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_PROC: begin
                kmac_process_o = 1'b1;
                cnt_d          = '0;
                state_d        = kmac_err_i ? ST_ERR : ST_WAIT_ABS;
            end
            ST_WAIT_ABS: begin
                if (kmac_err_i) begin
                    state_d = ST_ERR;
                end else if (!w_abs_true && !w_abs_false) begin
                    state_d = ST_ERR;
                end else if (w_abs_true && kmac_state_valid_i) begin
                    digest_d = kmac_state_i[0][DigestW-1:0]
                             ^ kmac_state_i[1][DigestW-1:0];
                    state_d  = ST_DONE;
                end else if (w_timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_DONE: begin
                kmac_done_o    = c_mubi4_true;
                digest_valid_o = 1'b1;
                state_d        = kmac_err_i ? ST_ERR : ST_IDLE;
            end
            ST_ERR: begin
                error_o  = 1'b1;
                shares_d = '0;
                if (err_clr_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Shares are cleared on the edge that enters ERR. This keeps them
        // off the core bus while the block is in ERR.
        if (state_d == ST_ERR) begin
            shares_d = '0;
        end
    end

    assign digest_o   = digest_q;
    assign kmac_msg_o = shares_q;

    // Only the low DigestW state bits carry the digest.
    generate
        if (DigestW < StateW) begin : g_unused_state
            logic w_unused_state;
            assign w_unused_state = ^{kmac_state_i[0][StateW-1:DigestW],
                                      kmac_state_i[1][StateW-1:DigestW]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kmac_sca_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmac_sca_sequencer
// Description : Directed self-checking bench for kmac_sca_sequencer. The core
//               model is driven by hand. State shares are chosen so that
//               their XOR is a known reference digest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmac_sca_sequencer;

    localparam int unsigned MsgLen  = 128;
    localparam int unsigned DigestW = 256;
    localparam int unsigned StateW  = 1600;
    localparam int unsigned TO      = 16;

    localparam logic [3:0] c_true  = 4'h6;
    localparam logic [3:0] c_false = 4'h9;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req;
    logic                   req_ready;
    logic [MsgLen-1:0]      msg, mask;
    logic [DigestW-1:0]     digest;
    logic                   dv;
    logic                   err;
    logic                   err_clr;
    logic [1:0][MsgLen-1:0] kmsg;
    logic                   kvalid, kready, kstart, kproc;
    logic [3:0]             kdone, kabs;
    logic [1:0][StateW-1:0] kstate;
    logic                   ksv, kerr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] c_msg1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    logic [127:0] c_mask1  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    logic [127:0] c_share1 = 128'hFEDC_4567_7654_CDEF_0123_BA98_89AB_3210;
    logic [127:0] c_msg2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    logic [127:0] c_mask2  = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    logic [127:0] c_share2 = 128'h1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878_8787;
    logic [255:0] c_dig1   = {4{64'hAAAA_AAAA_AAAA_AAAA}};

    always #5 clk = ~clk;

    kmac_sca_sequencer #(
        .MsgLen        (MsgLen),
        .DigestW       (DigestW),
        .StateW        (StateW),
        .TimeoutCycles (TO)
    ) u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_i              (req),
        .req_ready_o        (req_ready),
        .msg_i              (msg),
        .mask_i             (mask),
        .digest_o           (digest),
        .digest_valid_o     (dv),
        .error_o            (err),
        .err_clr_i          (err_clr),
        .kmac_msg_o         (kmsg),
        .kmac_msg_valid_o   (kvalid),
        .kmac_msg_ready_i   (kready),
        .kmac_start_o       (kstart),
        .kmac_process_o     (kproc),
        .kmac_done_o        (kdone),
        .kmac_absorbed_i    (kabs),
        .kmac_state_i       (kstate),
        .kmac_state_valid_i (ksv),
        .kmac_err_i         (kerr)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        msg     = '0;
        mask    = '0;
        err_clr = 1'b0;
        kready  = 1'b0;
        kabs    = c_false;
        kstate  = '0;
        ksv     = 1'b0;
        kerr    = 1'b0;
        #22;
        check("rst_req_ready", 256'(req_ready), 256'd1);
        check("rst_digest",    digest,          256'd0);
        check("rst_dv",        256'(dv),        256'd0);
        check("rst_error",     256'(err),       256'd0);
        check("rst_done",      256'(kdone),     256'(c_false));
        check("rst_start",     256'(kstart),    256'd0);
        check("rst_kmsg",      256'(kmsg),      256'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- basic hash, zero-stall core ----------------
        kready = 1'b1;
        kabs   = c_true;
        ksv    = 1'b1;
        kstate[0][255:0] = {4{64'hA5A5_A5A5_A5A5_A5A5}};
        kstate[1][255:0] = {4{64'h0F0F_0F0F_0F0F_0F0F}};
        kstate[0][1599:256] = {1344{1'b1}};
        msg  = c_msg1;
        mask = c_mask1;
        req  = 1'b1;
        tick();                                   // START
        req = 1'b0;
        check("b_start",      256'(kstart),    256'd1);
        check("b_req_ready",  256'(req_ready), 256'd0);
        check("b_share0",     256'(kmsg[0]),   256'(c_share1));
        check("b_share1",     256'(kmsg[1]),   256'(c_mask1));
        tick();                                   // MSG
        check("b_msg_valid",  256'(kvalid),    256'd1);
        check("b_start_off",  256'(kstart),    256'd0);
        tick();                                   // PROC
        check("b_process",    256'(kproc),     256'd1);
        check("b_shares_clr", 256'(kmsg),      256'd0);
        tick();                                   // WAIT_ABS
        check("b_dv_early",   256'(dv),        256'd0);
        check("b_done_early", 256'(kdone),     256'(c_false));
        tick();                                   // DONE, 5 edges after req
        check("b_dv",         256'(dv),        256'd1);
        check("b_done",       256'(kdone),     256'(c_true));
        check("b_digest",     digest,          c_dig1);
        tick();                                   // IDLE
        check("b_dv_pulse",   256'(dv),        256'd0);
        check("b_done_pulse", 256'(kdone),     256'(c_false));
        check("b_ready_back", 256'(req_ready), 256'd1);

        // ---------------- backpressure ----------------
        kready = 1'b0;
        msg    = c_msg2;
        mask   = c_mask2;
        req    = 1'b1;
        tick();                                   // START
        req = 1'b0;
        tick();                                   // MSG, cycle 0
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",  256'(kvalid),  256'd1);
            check("bp_share0", 256'(kmsg[0]), 256'(c_share2));
            check("bp_share1", 256'(kmsg[1]), 256'(c_mask2));
            tick();
        end
        check("bp_valid_end", 256'(kvalid),   256'd1);
        kready = 1'b1;
        tick();                                   // PROC
        check("bp_shares_clr", 256'(kmsg),    256'd0);
        check("bp_process",    256'(kproc),   256'd1);
        tick();                                   // WAIT_ABS
        tick();                                   // DONE
        check("bp_dv",         256'(dv),      256'd1);
        tick();                                   // IDLE

        // ---------------- timeout in MSG ----------------
        kready = 1'b0;
        req    = 1'b1;
        tick();                                   // START
        req = 1'b0;
        tick();                                   // MSG, cycle 0
        for (int i = 0; i < 15; i++) tick();      // MSG, cycle 15
        check("to_not_yet",   256'(err),       256'd0);
        check("to_valid",     256'(kvalid),    256'd1);
        tick();                                   // ERR
        check("to_error",     256'(err),       256'd1);
        check("to_valid_off", 256'(kvalid),    256'd0);
        check("to_kmsg_clr",  256'(kmsg),      256'd0);
        check("to_done",      256'(kdone),     256'(c_false));
        check("to_not_ready", 256'(req_ready), 256'd0);
        tick();
        check("to_sticky",    256'(err),       256'd1);
        err_clr = 1'b1;
        tick();                                   // IDLE
        err_clr = 1'b0;
        check("to_clr_err",   256'(err),       256'd0);
        check("to_clr_ready", 256'(req_ready), 256'd1);

        // ---------------- core error beats absorb success ----------------
        kready = 1'b1;
        kabs   = c_true;
        ksv    = 1'b1;
        kstate[0][255:0] = {4{64'h1234_5678_9ABC_DEF0}};
        req = 1'b1;
        tick();                                   // START
        req = 1'b0;
        tick();                                   // MSG
        tick();                                   // PROC
        tick();                                   // WAIT_ABS
        kerr = 1'b1;
        tick();                                   // ERR
        kerr = 1'b0;
        check("ep_error",     256'(err),       256'd1);
        check("ep_no_dv",     256'(dv),        256'd0);
        check("ep_done",      256'(kdone),     256'(c_false));
        check("ep_digest",    digest,          c_dig1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ep_idle",      256'(req_ready), 256'd1);

        // ---------------- invalid mubi absorbed ----------------
        kabs = 4'h0;
        req  = 1'b1;
        tick();                                   // START
        req = 1'b0;
        tick();                                   // MSG
        tick();                                   // PROC
        tick();                                   // WAIT_ABS
        check("mb_wait",      256'(err),       256'd0);
        tick();                                   // ERR
        check("mb_error",     256'(err),       256'd1);
        check("mb_no_dv",     256'(dv),        256'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // ---------------- ignored req, then reset in WAIT_ABS ----------------
        kabs = c_false;
        ksv  = 1'b0;
        req  = 1'b1;
        tick();                                   // START
        req = 1'b0;
        tick();                                   // MSG
        tick();                                   // PROC
        tick();                                   // WAIT_ABS
        req = 1'b1;
        tick();                                   // still WAIT_ABS
        req = 1'b0;
        check("ig_start",     256'(kstart),    256'd0);
        check("ig_ready",     256'(req_ready), 256'd0);
        check("ig_valid",     256'(kvalid),    256'd0);
        tick();
        check("ig_start2",    256'(kstart),    256'd0);
        rst_n = 1'b0;
        #2;
        check("rs_ready",     256'(req_ready), 256'd1);
        check("rs_digest",    digest,          256'd0);
        check("rs_done",      256'(kdone),     256'(c_false));
        check("rs_dv",        256'(dv),        256'd0);
        check("rs_error",     256'(err),       256'd0);
        check("rs_process",   256'(kproc),     256'd0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
